urv_pipe_ctrl: RTL and testbench
================================

# urv_pipe_ctrl

Parametrised pipeline control unit for uRV cores. It generates per-stage stall and kill strobes for an N-stage in-order pipeline, from per-stage stall requests and a branch/exception flush shadow of configurable depth. It adds a debug halt/resume/single-step state machine and a stall-cycle performance counter. It sits at the top of the core, between the stage modules and the debug module.

## Interface
- `g_num_stages`, default 4: number of pipeline stages. Stage 0 is fetch; stage `g_num_stages-1` is writeback. Legal range 3..8.
- `g_branch_stage`, default 2: index of the stage that resolves branches and raises exceptions. Legal range 1..`g_num_stages-2`.
- `g_self_stall_mask`, default 4'b0100: if bit s is set, stage s is stalled by its own request.
- `g_with_hw_debug`, default 0: when 0, the debug FSM is held in RUN.
- `clk_i`  in  1  single clock. All state changes on the rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `stall_req_i`  in  g_num_stages  per-stage stall request.
- `valid_i`  in  g_num_stages  per-stage "holds a valid instruction" flag.
- `branch_take_i`  in  1  taken branch, from stage `g_branch_stage`.
- `exc_i`  in  1  exception/trap entry, from stage `g_branch_stage`.
- `dbg_halt_req_i`, `dbg_resume_i`, `dbg_step_i`  in  1 each  debug requests. These are level inputs sampled each cycle.
- `cnt_clr_i`  in  1  synchronous clear of the stall counter.
- `stall_o`  out  g_num_stages  per-stage stall.
- `kill_o`  out  g_num_stages  per-stage kill (the stage's output becomes a bubble).
- `dbg_halted_o`  out  1  the core is halted and drained.
- `stall_cycles_o`  out  32  stall-cycle counter.

## Operation
- **Flush:** `flush = branch_take_i | exc_i`.
- **Stall:** `stall_o[s]` = OR of `stall_req_i[k]` for k>s, OR (`stall_req_i[s] & g_self_stall_mask[s]`). Force `stall_o[0]=1` when state is HALT_REQ or HALTED.
- **Last stage:** `stall_o[g_num_stages-1]` is 1 only via its own mask bit. With defaults it is always 0.
- **Shadow shift register:** `sh[0..g_branch_stage-1]`.
  - When `stall_o[g_branch_stage]==0`: `sh[0]<=flush`, `sh[i]<=sh[i-1]`.
  - Otherwise the register holds.
- **Kill, stages s ≤ `g_branch_stage`:** `kill_o[s]` = `flush` | OR of `sh[0..s-1]`.
  - Defaults give kill[0]=flush, kill[1]=flush|sh0, kill[2]=flush|sh0|sh1.
- **Kill, stages above `g_branch_stage`:** `kill_o[s]=0`, except the forced kill below.
- **Forced kill:** `kill_o[1]` is forced to 1 in HALT_REQ and HALTED, so decode receives bubbles.
- **Debug FSM** (`g_with_hw_debug=1`). States RUN, HALT_REQ, HALTED, STEP.
  - RUN: `dbg_halt_req_i` → HALT_REQ.
  - HALT_REQ: when `valid_i[g_num_stages-1:1]==0` and `flush==0` → HALTED.
  - HALTED: `dbg_resume_i` → RUN. Otherwise `dbg_step_i` → STEP. Resume has priority over step.
  - STEP: the stage-0 stall is not forced. When `stall_o[0]==0 && valid_i[0]` (one instruction handed to decode) → HALT_REQ.
  - A `dbg_halt_req_i` seen in HALT_REQ, HALTED or STEP is ignored.
- `dbg_halted_o` = (state==HALTED), registered with the state.
- **Stall counter:**
  - Increments when state==RUN and `stall_o[0]==1`.
  - Saturates at 0xFFFF_FFFF.
  - `cnt_clr_i` has priority and loads 0. If clear and increment coincide, the result is 0.

## Timing
- **Reset values:** `sh` all 0, state RUN, `dbg_halted_o=0`, `stall_cycles_o=0`.
- **Outputs during reset:** while `rst_n_i` is low, `kill_o` is all ones and `stall_o` is all zeros. These outputs are combinationally gated by reset.
- **Latency:** `stall_o` and `kill_o` are combinational from the inputs and current state, with zero latency. The shadow delays flush by 1..`g_branch_stage` un-stalled cycles.
- **Simultaneous events:**
  - A flush during a stall of the branch stage: `kill_o` asserts immediately, and the shadow captures the flush on the first un-stalled edge.
  - A flush in HALT_REQ delays the move to HALTED by at least one cycle.
- **Deassertion:** reset deassertion is synchronised externally. The FSM leaves RUN at the earliest on the first edge after release.

## Structure
- `urv_defs.v` gains the FSM state encodings `URV_PCTL_RUN`, `URV_PCTL_HALT_REQ`, `URV_PCTL_HALTED` and `URV_PCTL_STEP`.
- One sub-module, `urv_sat_counter` (parametrised width, saturating, with synchronous clear), used for `stall_cycles_o`.

## Test plan
- **Reset:** assert `rst_n_i`=0 mid-stream → `kill_o=4'b1111`, `stall_o=0`. After release → `sh=0`, counter 0, `dbg_halted_o=0`.
- **Stall rule, defaults:** `stall_req_i=4'b0100` → `stall_o=4'b0111`. `stall_req_i=4'b0010` → `stall_o=4'b0001`. `stall_req_i=4'b1000` → `stall_o=4'b0111`.
- **Branch shadow:** single-cycle `branch_take_i`, no stalls → cycle 0 `kill_o=4'b0111`, cycle 1 `4'b0110`, cycle 2 `4'b0100`, cycle 3 `0`. Repeat with `stall_req_i[2]` held for 3 cycles after the branch → the shadow is frozen for those 3 cycles.
- **Halt/step:** `g_with_hw_debug=1`, halt request with 3 valid stages → `dbg_halted_o` rises once `valid_i[3:1]=0`.
  - Then `dbg_step_i` → exactly one cycle with `stall_o[0]=0` and `valid_i[0]=1`, then back to HALTED after drain.
  - Resume and step together → RUN.
- **Counter:** hold `stall_req_i=4'b0100` for 10 cycles → `stall_cycles_o=10`. `cnt_clr_i` together with a stall → 0. Preload near max → sticks at 0xFFFF_FFFF.
- **Parametrisation:** `g_num_stages=6`, `g_branch_stage=3`, flush → kill pattern `6'b001111`, `6'b001110`, `6'b001100`, `6'b001000`, then 0.

Source files
------------

// File: rtl/urv_pipe_ctrl_pkg.sv
// Shared types and helpers for the uRV pipeline control unit.
package urv_pipe_ctrl_pkg;

   localparam int unsigned URV_MAX_STAGES = 8;

   typedef enum logic [1:0] {
      URV_PCTL_RUN      = 2'd0,
      URV_PCTL_HALT_REQ = 2'd1,
      URV_PCTL_HALTED   = 2'd2,
      URV_PCTL_STEP     = 2'd3
   } pctl_state_e;

   // True when any request bit strictly above idx is set.
   function automatic logic any_above(input logic [URV_MAX_STAGES-1:0] vec,
                                      input int unsigned idx);
      logic [URV_MAX_STAGES-1:0] shifted_s;
      shifted_s = vec >> (idx + 32'd1);
      return |shifted_s;
   endfunction

endpackage

// File: rtl/urv_pipe_ctrl_if.sv
// Stage-side bundle: stall requests, valids and flush sources in, stall/kill out.
interface urv_pipe_ctrl_if #(
   parameter int unsigned g_num_stages = 4
);
   logic [g_num_stages-1:0] stall_req;
   logic [g_num_stages-1:0] valid;
   logic                    branch_take;
   logic                    exc;
   logic [g_num_stages-1:0] stall;
   logic [g_num_stages-1:0] kill;

   modport master (output stall_req, valid, branch_take, exc, input stall, kill);
   modport slave  (input stall_req, valid, branch_take, exc, output stall, kill);
endinterface

// File: rtl/urv_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module urv_sat_counter #(
   parameter int unsigned g_width = 32
)(
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               clr_i,
   input  logic               inc_i,
   output logic [g_width-1:0] cnt_o
);

   // Count register: clear wins, then saturating increment.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= '0;
      end else if (inc_i && (cnt_o != '1)) begin
         cnt_o <= cnt_o + g_width'(1);
      end else begin
         cnt_o <= cnt_o;
      end
   end

endmodule

// File: rtl/urv_pipe_ctrl.sv
// uRV pipeline control: per-stage stall/kill, branch flush shadow,
// debug halt/resume/step FSM and stall-cycle counter.
module urv_pipe_ctrl
   import urv_pipe_ctrl_pkg::*;
#(
   parameter int unsigned             g_num_stages      = 4,
   parameter int unsigned             g_branch_stage    = 2,
   parameter logic [g_num_stages-1:0] g_self_stall_mask = g_num_stages'(1'b1) << g_branch_stage,
   parameter bit                      g_with_hw_debug   = 1'b0
)(
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   urv_pipe_ctrl_if.slave        pipe,
   input  logic                  dbg_halt_req_i,
   input  logic                  dbg_resume_i,
   input  logic                  dbg_step_i,
   input  logic                  cnt_clr_i,
   output logic                  dbg_halted_o,
   output logic [31:0]           stall_cycles_o
);

   localparam int unsigned NS = g_num_stages;
   localparam int unsigned BS = g_branch_stage;

   logic                      flush_s;
   logic                      halt_force_s;
   logic                      drained_s;
   logic                      step_taken_s;
   logic                      cnt_inc_s;
   logic [URV_MAX_STAGES-1:0] req_ext_s;
   logic [NS-1:0]             stall_s;
   logic [NS-1:0]             kill_s;
   logic [BS-1:0]             sh_r;
   pctl_state_e               state_r;
   logic                      dbg_halted_r;

   // Stall and kill vectors from requests, flush shadow and debug state.
   always_comb begin
      flush_s      = pipe.branch_take | pipe.exc;
      halt_force_s = (state_r == URV_PCTL_HALT_REQ) || (state_r == URV_PCTL_HALTED);
      req_ext_s    = URV_MAX_STAGES'(pipe.stall_req);
      stall_s      = '0;
      kill_s       = '0;
      for (int unsigned s = 0; s < NS; s++) begin
         stall_s[s] = any_above(req_ext_s, s) | (pipe.stall_req[s] & g_self_stall_mask[s]);
      end
      stall_s[0] = stall_s[0] | halt_force_s;
      // Stages up to the branch stage are killed by a live flush or any older shadow bit.
      for (int unsigned s = 0; s <= BS; s++) begin
         kill_s[s] = flush_s;
         for (int unsigned i = 0; i < s; i++) begin
            kill_s[s] = kill_s[s] | sh_r[i];
         end
      end
      kill_s[1]    = kill_s[1] | halt_force_s;
      drained_s    = (pipe.valid[NS-1:1] == '0) && !flush_s;
      step_taken_s = !stall_s[0] && pipe.valid[0];
      cnt_inc_s    = (state_r == URV_PCTL_RUN) && stall_s[0];
   end

   // While in reset every stage is held as a bubble and nothing stalls.
   always_comb begin
      if (rst_n_i) begin
         pipe.stall = stall_s;
         pipe.kill  = kill_s;
      end else begin
         pipe.stall = '0;
         pipe.kill  = '1;
      end
   end

   // Flush shadow: advances only when the branch stage moves.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sh_r <= '0;
      end else if (!stall_s[BS]) begin
         sh_r <= BS'({sh_r, flush_s});
      end else begin
         sh_r <= sh_r;
      end
   end

   // Debug state machine with registered halted flag.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r      <= URV_PCTL_RUN;
         dbg_halted_r <= 1'b0;
      end else if (!g_with_hw_debug) begin
         state_r      <= URV_PCTL_RUN;
         dbg_halted_r <= 1'b0;
      end else begin
         case (state_r)
            URV_PCTL_RUN: begin
               if (dbg_halt_req_i) begin
                  state_r <= URV_PCTL_HALT_REQ;
               end else begin
                  state_r <= URV_PCTL_RUN;
               end
               dbg_halted_r <= 1'b0;
            end
            URV_PCTL_HALT_REQ: begin
               if (drained_s) begin
                  state_r      <= URV_PCTL_HALTED;
                  dbg_halted_r <= 1'b1;
               end else begin
                  state_r      <= URV_PCTL_HALT_REQ;
                  dbg_halted_r <= 1'b0;
               end
            end
            URV_PCTL_HALTED: begin
               if (dbg_resume_i) begin
                  state_r      <= URV_PCTL_RUN;
                  dbg_halted_r <= 1'b0;
               end else if (dbg_step_i) begin
                  state_r      <= URV_PCTL_STEP;
                  dbg_halted_r <= 1'b0;
               end else begin
                  state_r      <= URV_PCTL_HALTED;
                  dbg_halted_r <= 1'b1;
               end
            end
            URV_PCTL_STEP: begin
               if (step_taken_s) begin
                  state_r <= URV_PCTL_HALT_REQ;
               end else begin
                  state_r <= URV_PCTL_STEP;
               end
               dbg_halted_r <= 1'b0;
            end
            default: begin
               state_r      <= URV_PCTL_RUN;
               dbg_halted_r <= 1'b0;
            end
         endcase
      end
   end

   assign dbg_halted_o = dbg_halted_r;

   urv_sat_counter #(
      .g_width (32)
   ) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (cnt_clr_i),
      .inc_i   (cnt_inc_s),
      .cnt_o   (stall_cycles_o)
   );

endmodule

// File: tb/tb_urv_pipe_ctrl.sv
// Directed bench for urv_pipe_ctrl: stall/kill table plus debug, counter,
// reset and 6-stage sequences.
module tb_urv_pipe_ctrl;

   logic        clk;
   logic        rst_n;
   logic        dbg_halt, dbg_resume, dbg_step, cnt_clr;
   logic        halted;
   logic [31:0] cnt;
   logic        d6_halt, d6_resume, d6_step, d6_clr;
   logic        d6_halted;
   logic [31:0] cnt6;
   logic        sat_clr, sat_inc;
   logic [3:0]  sat_cnt;
   int          total;
   int          bad;

   urv_pipe_ctrl_if #(.g_num_stages(4)) p4();
   urv_pipe_ctrl_if #(.g_num_stages(6)) p6();

   urv_pipe_ctrl #(
      .g_num_stages(4), .g_branch_stage(2), .g_with_hw_debug(1'b1)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .pipe(p4),
      .dbg_halt_req_i(dbg_halt), .dbg_resume_i(dbg_resume), .dbg_step_i(dbg_step),
      .cnt_clr_i(cnt_clr), .dbg_halted_o(halted), .stall_cycles_o(cnt)
   );

   urv_pipe_ctrl #(
      .g_num_stages(6), .g_branch_stage(3), .g_with_hw_debug(1'b0)
   ) dut6 (
      .clk_i(clk), .rst_n_i(rst_n), .pipe(p6),
      .dbg_halt_req_i(d6_halt), .dbg_resume_i(d6_resume), .dbg_step_i(d6_step),
      .cnt_clr_i(d6_clr), .dbg_halted_o(d6_halted), .stall_cycles_o(cnt6)
   );

   urv_sat_counter #(.g_width(4)) u_sat (
      .clk_i(clk), .rst_n_i(rst_n), .clr_i(sat_clr), .inc_i(sat_inc), .cnt_o(sat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic       br;
      logic       exc;
      logic [3:0] exp_stall;
      logic [3:0] exp_kill;
   } vec_t;

   vec_t tbl[22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      tbl[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000};
      tbl[1]  = '{4'b0100, 1'b0, 1'b0, 4'b0111, 4'b0000};
      tbl[2]  = '{4'b0010, 1'b0, 1'b0, 4'b0001, 4'b0000};
      tbl[3]  = '{4'b1000, 1'b0, 1'b0, 4'b0111, 4'b0000};
      tbl[4]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000};
      tbl[5]  = '{4'b0110, 1'b0, 1'b0, 4'b0111, 4'b0000};
      tbl[6]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0111};
      tbl[7]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0110};
      tbl[8]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0100};
      tbl[9]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000};
      tbl[10] = '{4'b0100, 1'b0, 1'b1, 4'b0111, 4'b0111};
      tbl[11] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0111};
      tbl[12] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0110};
      tbl[13] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0100};
      tbl[14] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000};
      tbl[15] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0111};
      tbl[16] = '{4'b0100, 1'b0, 1'b0, 4'b0111, 4'b0110};
      tbl[17] = '{4'b0100, 1'b0, 1'b0, 4'b0111, 4'b0110};
      tbl[18] = '{4'b0100, 1'b0, 1'b0, 4'b0111, 4'b0110};
      tbl[19] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0110};
      tbl[20] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0100};
      tbl[21] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000};

      rst_n = 1'b0;
      dbg_halt = 1'b0; dbg_resume = 1'b0; dbg_step = 1'b0; cnt_clr = 1'b0;
      d6_halt = 1'b0; d6_resume = 1'b0; d6_step = 1'b0; d6_clr = 1'b0;
      sat_clr = 1'b0; sat_inc = 1'b0;
      p4.stall_req = 4'b0100; p4.valid = 4'b0000; p4.branch_take = 1'b0; p4.exc = 1'b0;
      p6.stall_req = 6'b000000; p6.valid = 6'b000000; p6.branch_take = 1'b0; p6.exc = 1'b0;
      #2;
      chk("rst_kill", 32'(p4.kill), 32'h0000000F);
      chk("rst_stall", 32'(p4.stall), 32'h00000000);
      chk("rst_kill6", 32'(p6.kill), 32'h0000003F);

      @(negedge clk);
      rst_n = 1'b1;
      p4.stall_req = 4'b0000;
      #1;
      chk("post_rst_kill", 32'(p4.kill), 32'h0);
      chk("post_rst_halted", 32'(halted), 32'h0);
      chk("post_rst_cnt", cnt, 32'h0);

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         p4.stall_req   = tbl[i].req;
         p4.branch_take = tbl[i].br;
         p4.exc         = tbl[i].exc;
         #1;
         chk($sformatf("tbl%0d_stall", i), 32'(p4.stall), 32'(tbl[i].exp_stall));
         chk($sformatf("tbl%0d_kill", i), 32'(p4.kill), 32'(tbl[i].exp_kill));
      end

      // Mid-stream reset with a live shadow bit and a non-zero counter.
      @(negedge clk);
      p4.branch_take = 1'b1;
      @(negedge clk);
      p4.branch_take = 1'b0;
      rst_n = 1'b0;
      p4.stall_req = 4'b0100;
      #1;
      chk("mid_rst_kill", 32'(p4.kill), 32'h0000000F);
      chk("mid_rst_stall", 32'(p4.stall), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      p4.stall_req = 4'b0000;
      #1;
      chk("mid_rst_sh", 32'(p4.kill), 32'h0);
      chk("mid_rst_cnt", cnt, 32'h0);
      chk("mid_rst_halted", 32'(halted), 32'h0);

      // Stall counter: ten stalled cycles, then clear coinciding with a stall.
      @(negedge clk);
      p4.stall_req = 4'b0100;
      repeat (10) @(posedge clk);
      @(negedge clk);
      p4.stall_req = 4'b0000;
      #1;
      chk("cnt_10", cnt, 32'd10);
      @(negedge clk);
      p4.stall_req = 4'b0100;
      cnt_clr = 1'b1;
      @(negedge clk);
      p4.stall_req = 4'b0000;
      cnt_clr = 1'b0;
      #1;
      chk("cnt_clr_vs_inc", cnt, 32'd0);

      // Saturation on a narrow instance of the same counter.
      @(negedge clk);
      sat_inc = 1'b1;
      repeat (14) @(posedge clk);
      @(negedge clk);
      #1;
      chk("sat_14", 32'(sat_cnt), 32'd14);
      repeat (6) @(posedge clk);
      @(negedge clk);
      #1;
      chk("sat_max", 32'(sat_cnt), 32'd15);
      sat_clr = 1'b1;
      @(negedge clk);
      sat_clr = 1'b0;
      sat_inc = 1'b0;
      #1;
      chk("sat_clr", 32'(sat_cnt), 32'd0);

      // Halt request with three valid stages, delayed by a flush.
      @(negedge clk);
      dbg_halt = 1'b1;
      p4.valid = 4'b1110;
      #1;
      chk("run_stall", 32'(p4.stall), 32'h0);
      @(negedge clk);
      dbg_halt = 1'b0;
      #1;
      chk("hreq_stall", 32'(p4.stall), 32'h1);
      chk("hreq_kill", 32'(p4.kill), 32'h2);
      chk("hreq_halted", 32'(halted), 32'h0);
      @(negedge clk);
      p4.valid = 4'b0000;
      p4.branch_take = 1'b1;
      #1;
      chk("hreq_flush_kill", 32'(p4.kill), 32'h7);
      @(negedge clk);
      p4.branch_take = 1'b0;
      #1;
      chk("hreq_flush_delay", 32'(halted), 32'h0);
      chk("hreq_sh_kill", 32'(p4.kill), 32'h6);
      @(negedge clk);
      #1;
      chk("halted_rise", 32'(halted), 32'h1);
      chk("halted_stall", 32'(p4.stall), 32'h1);
      chk("halted_kill", 32'(p4.kill), 32'h6);
      @(negedge clk);
      #1;
      chk("halted_kill_forced", 32'(p4.kill), 32'h2);
      chk("halted_cnt", cnt, 32'h0);

      // Single step: one un-stalled fetch hand-off, then drain back to HALTED.
      @(negedge clk);
      dbg_step = 1'b1;
      p4.valid = 4'b0001;
      #1;
      chk("pre_step_stall", 32'(p4.stall), 32'h1);
      @(negedge clk);
      dbg_step = 1'b0;
      #1;
      chk("step_stall", 32'(p4.stall), 32'h0);
      chk("step_kill", 32'(p4.kill), 32'h0);
      chk("step_halted", 32'(halted), 32'h0);
      @(negedge clk);
      p4.valid = 4'b0010;
      #1;
      chk("post_step_stall", 32'(p4.stall), 32'h1);
      chk("post_step_kill", 32'(p4.kill), 32'h2);
      @(negedge clk);
      p4.valid = 4'b0000;
      #1;
      chk("post_step_draining", 32'(halted), 32'h0);
      @(negedge clk);
      #1;
      chk("step_rehalted", 32'(halted), 32'h1);

      // Resume and step together: resume wins.
      @(negedge clk);
      dbg_resume = 1'b1;
      dbg_step = 1'b1;
      @(negedge clk);
      dbg_resume = 1'b0;
      dbg_step = 1'b0;
      #1;
      chk("resume_halted", 32'(halted), 32'h0);
      chk("resume_stall", 32'(p4.stall), 32'h0);
      chk("resume_kill", 32'(p4.kill), 32'h0);

      // Six-stage instance, branch stage 3, no hardware debug.
      @(negedge clk);
      d6_halt = 1'b1;
      p6.branch_take = 1'b1;
      #1;
      chk("k6_0", 32'(p6.kill), 32'h0F);
      @(negedge clk);
      d6_halt = 1'b0;
      p6.branch_take = 1'b0;
      #1;
      chk("k6_1", 32'(p6.kill), 32'h0E);
      chk("k6_nodbg_stall", 32'(p6.stall), 32'h0);
      chk("k6_nodbg_halted", 32'(d6_halted), 32'h0);
      @(negedge clk);
      #1;
      chk("k6_2", 32'(p6.kill), 32'h0C);
      @(negedge clk);
      #1;
      chk("k6_3", 32'(p6.kill), 32'h08);
      @(negedge clk);
      #1;
      chk("k6_4", 32'(p6.kill), 32'h00);
      p6.stall_req = 6'b100000;
      #1;
      chk("s6_top", 32'(p6.stall), 32'h1F);
      p6.stall_req = 6'b001000;
      #1;
      chk("s6_self", 32'(p6.stall), 32'h0F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
